// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencing controller: walks FETCH/DECODE/EXEC/MEM/WB one phase per
// cycle and emits the datapath control word for the instruction held in IR.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             wb_src,
  output logic             alu_src_b,
  output logic             ext_sign,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             illegal_q, illegal_set;
  logic [CNT_W-1:0] retired_q;

  logic       known, is_r, i_j, i_jr, i_halt, i_ori, i_lw, i_sw, i_beq, i_bne, use_imm;
  logic [2:0] alu_sel;

  // Instruction classification; op/func stay stable from DECODE until the next fetch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    known   = 1'b1;
    is_r    = (op == OP_R);
    i_j     = 1'b0;
    i_jr    = 1'b0;
    i_halt  = 1'b0;
    i_ori   = 1'b0;
    i_lw    = 1'b0;
    i_sw    = 1'b0;
    i_beq   = 1'b0;
    i_bne   = 1'b0;
    use_imm = 1'b0;
    alu_sel = ALU_ADD;
    case (op)
      OP_R: begin
        case (func)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          FN_SLL:  alu_sel = ALU_SLL;
          FN_JR:   i_jr    = 1'b1;
          default: known   = 1'b0;
        endcase
      end
      OP_ADDI: use_imm = 1'b1;
      OP_ORI:  begin i_ori = 1'b1; use_imm = 1'b1; alu_sel = ALU_OR; end
      OP_LW:   begin i_lw  = 1'b1; use_imm = 1'b1; end
      OP_SW:   begin i_sw  = 1'b1; use_imm = 1'b1; end
      OP_BEQ:  begin i_beq = 1'b1; alu_sel = ALU_SUB; end
      OP_BNE:  begin i_bne = 1'b1; alu_sel = ALU_SUB; end
      OP_J:    i_j    = 1'b1;
      OP_HALT: i_halt = 1'b1;
      default: known  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    wb_src      = 1'b0;
    alu_src_b   = 1'b0;
    ext_sign    = 1'b0;
    alu_op      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (i_j) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          state_d = S_FETCH;
        end else if (i_jr) begin
          pc_we   = 1'b1;
          pc_src  = 2'd3;
          state_d = S_FETCH;
        end else if (i_halt) begin
          state_d = S_HALT;
        end else if (!known) begin
          illegal_set = 1'b1;
          state_d     = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op    = alu_sel;
        alu_src_b = use_imm;
        ext_sign  = !i_ori;
        if (i_beq || i_bne) begin
          pc_we   = i_beq ? zero : !zero;
          pc_src  = 2'd1;
          state_d = S_FETCH;
        end else if (i_lw || i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = i_sw;
        alu_op    = alu_sel;
        alu_src_b = use_imm;
        if (dmem_ready) state_d = i_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we    = 1'b1;
        reg_dst   = is_r;
        wb_src    = i_lw;
        alu_op    = alu_sel;
        alu_src_b = use_imm;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset cycle: nothing may fire into the datapath or memories.
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      reg_we    = 1'b0;
      reg_dst   = 1'b0;
      wb_src    = 1'b0;
      alu_src_b = 1'b0;
      ext_sign  = 1'b0;
      alu_op    = ALU_ADD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
      // Halt/illegal go to HALT, never to FETCH, so they are never counted.
      if (state_q != S_FETCH && state_d == S_FETCH) retired_q <= retired_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle state and control-word checks
// against hand-computed vectors, with a 4-bit retired counter to reach wrap-around.
module tb_mc_control_fsm;

  localparam int CW = 4;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5;

  // Control word layout: {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_src[1:0],
  //                       reg_we,reg_dst,wb_src,alu_src_b,ext_sign,alu_op[2:0]}
  localparam logic [14:0] IREQ = 15'h4000, DREQ = 15'h2000, DWE  = 15'h1000;
  localparam logic [14:0] IRWE = 15'h0800, PCWE = 15'h0400;
  localparam logic [14:0] PBR  = 15'h0100, PJ   = 15'h0200, PJR  = 15'h0300;
  localparam logic [14:0] RWE  = 15'h0080, RDST = 15'h0040, WBM  = 15'h0020;
  localparam logic [14:0] IMM  = 15'h0010, SEXT = 15'h0008;
  localparam logic [14:0] ADD = 15'd0, SUB = 15'd1, AOR = 15'd3, SLT = 15'd4, SLL = 15'd5;
  localparam logic [14:0] FETCHED = IREQ | IRWE | PCWE;

  logic          clk = 1'b0;
  logic          rst, zero, imem_ready, dmem_ready;
  logic [5:0]    op, func;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, reg_dst, wb_src;
  logic          alu_src_b, ext_sign, halted, illegal;
  logic [1:0]    pc_src;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] retired;
  logic [14:0]   ctl;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .wb_src(wb_src), .alu_src_b(alu_src_b), .ext_sign(ext_sign), .alu_op(alu_op),
    .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  assign ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                reg_we, reg_dst, wb_src, alu_src_b, ext_sign, alu_op};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check state and control word mid-cycle, then advance past the edge.
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic ir, input logic dr, input logic [2:0] es, input logic [14:0] ec);
    op = o; func = f; zero = z; imem_ready = ir; dmem_ready = dr;
    #1;
    check({tag, "/state"}, 32'(state), 32'(es));
    check({tag, "/ctl"},   32'(ctl),   32'(ec));
    @(posedge clk); #1;
  endtask

  task automatic do_j(input string tag);
    run({tag, ".F"}, 6'h02, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run({tag, ".D"}, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0, SD, PCWE | PJ);
  endtask

  task automatic do_add(input string tag);
    run({tag, ".F"}, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run({tag, ".D"}, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run({tag, ".E"}, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, SE, SEXT | ADD);
    run({tag, ".W"}, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, SW, RWE | RDST | ADD);
  endtask

  task automatic pulse_reset(input string tag, input logic [2:0] es);
    rst = 1'b1;
    run({tag, ".rst"}, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, es, 15'd0);
    rst = 1'b0;
    check({tag, ".retired"}, 32'(retired), 32'd0);
    check({tag, ".halted"},  32'(halted),  32'd0);
    check({tag, ".illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    rst = 1'b1; op = '0; func = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b1;
    #1;
    check("reset.state",   32'(state),   32'(SF));
    check("reset.ctl",     32'(ctl),     32'd0);
    check("reset.retired", 32'(retired), 32'd0);
    check("reset.halted",  32'(halted),  32'd0);
    check("reset.illegal", 32'(illegal), 32'd0);
    rst = 1'b0;

    do_add("add");
    check("add.retired", 32'(retired), 32'd1);

    // lw with three wait cycles; a stray imem_ready during MEM is ignored
    run("lw.F",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("lw.D",  6'h23, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("lw.E",  6'h23, 6'h00, 1'b0, 1'b0, 1'b0, SE, IMM | SEXT | ADD);
    run("lw.M0", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, SM, DREQ | IMM | ADD);
    run("lw.M1", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, SM, DREQ | IMM | ADD);
    run("lw.M2", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, SM, DREQ | IMM | ADD);
    run("lw.M3", 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, SM, DREQ | IMM | ADD);
    run("lw.W",  6'h23, 6'h00, 1'b0, 1'b0, 1'b0, SW, RWE | WBM | IMM | ADD);
    check("lw.retired", 32'(retired), 32'd2);

    // beq taken after one fetch wait cycle, then bne not taken
    run("beq.F0", 6'h04, 6'h00, 1'b1, 1'b0, 1'b0, SF, IREQ);
    run("beq.F1", 6'h04, 6'h00, 1'b1, 1'b1, 1'b0, SF, FETCHED);
    run("beq.D",  6'h04, 6'h00, 1'b1, 1'b0, 1'b0, SD, 15'd0);
    run("beq.E",  6'h04, 6'h00, 1'b1, 1'b0, 1'b0, SE, PCWE | PBR | SEXT | SUB);
    run("bne.F",  6'h05, 6'h00, 1'b1, 1'b1, 1'b0, SF, FETCHED);
    run("bne.D",  6'h05, 6'h00, 1'b1, 1'b0, 1'b0, SD, 15'd0);
    run("bne.E",  6'h05, 6'h00, 1'b1, 1'b0, 1'b0, SE, PBR | SEXT | SUB);
    check("bne.retired", 32'(retired), 32'd4);

    do_j("j");
    run("jr.F",  6'h00, 6'h08, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("jr.D",  6'h00, 6'h08, 1'b0, 1'b0, 1'b0, SD, PCWE | PJR);
    check("jr.retired", 32'(retired), 32'd6);

    run("ori.F",  6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("ori.D",  6'h0D, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("ori.E",  6'h0D, 6'h00, 1'b0, 1'b0, 1'b0, SE, IMM | AOR);
    run("ori.W",  6'h0D, 6'h00, 1'b0, 1'b0, 1'b0, SW, RWE | IMM | AOR);
    run("addi.F", 6'h08, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("addi.D", 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("addi.E", 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, SE, IMM | SEXT | ADD);
    run("addi.W", 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, SW, RWE | IMM | ADD);
    run("slt.F",  6'h00, 6'h2A, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("slt.D",  6'h00, 6'h2A, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("slt.E",  6'h00, 6'h2A, 1'b0, 1'b0, 1'b0, SE, SEXT | SLT);
    run("slt.W",  6'h00, 6'h2A, 1'b0, 1'b0, 1'b0, SW, RWE | RDST | SLT);
    run("sll.F",  6'h00, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("sll.D",  6'h00, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("sll.E",  6'h00, 6'h00, 1'b0, 1'b0, 1'b0, SE, SEXT | SLL);
    run("sll.W",  6'h00, 6'h00, 1'b0, 1'b0, 1'b0, SW, RWE | RDST | SLL);
    run("sw.F",   6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("sw.D",   6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("sw.E",   6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, SE, IMM | SEXT | ADD);
    run("sw.M",   6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, SM, DREQ | DWE | IMM | ADD);
    check("sw.retired", 32'(retired), 32'd11);

    // 4-bit counter: five more retirements wrap 11 -> 0, one more gives 1
    for (int i = 0; i < 5; i++) do_j("jwrap");
    check("wrap.retired", 32'(retired), 32'd0);
    do_j("jpost");
    check("post.retired", 32'(retired), 32'd1);

    // halt is absorbing and requests nothing, even with both ready inputs high
    run("halt.F", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("halt.D", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, SD, 15'd0);
    for (int i = 0; i < 10; i++) begin
      check("halt.halted",  32'(halted),  32'd1);
      check("halt.illegal", 32'(illegal), 32'd0);
      check("halt.retired", 32'(retired), 32'd1);
      run("halt.H", 6'h3F, 6'h00, 1'b1, 1'b1, 1'b1, SH, 15'd0);
    end

    pulse_reset("hrst", SH);
    do_add("add2");
    run("ill.F", 6'h01, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("ill.D", 6'h01, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    check("ill.halted",  32'(halted),  32'd1);
    check("ill.illegal", 32'(illegal), 32'd1);
    check("ill.retired", 32'(retired), 32'd1);
    run("ill.H", 6'h01, 6'h00, 1'b0, 1'b1, 1'b1, SH, 15'd0);

    pulse_reset("irst", SH);
    run("illf.F", 6'h00, 6'h09, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("illf.D", 6'h00, 6'h09, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    check("illf.illegal", 32'(illegal), 32'd1);
    check("illf.retired", 32'(retired), 32'd0);

    // reset in the middle of a stalled sw; imem_ready pulses during MEM are ignored
    pulse_reset("frst", SH);
    do_add("add3");
    run("swr.F",  6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, SF, FETCHED);
    run("swr.D",  6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, SD, 15'd0);
    run("swr.E",  6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, SE, IMM | SEXT | ADD);
    run("swr.M0", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, SM, DREQ | DWE | IMM | ADD);
    run("swr.M1", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, SM, DREQ | DWE | IMM | ADD);
    check("swr.retired_pre", 32'(retired), 32'd1);
    pulse_reset("mrst", SM);
    run("swr.after", 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, SF, IREQ);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
